srt2_in_packer: RTL and testbench
=================================

Name: srt2_in_packer

Overview:
- Input stage of the SRT radix-2 divider top; sits directly upstream of the divider core.
- Collects eight bytes from the byte-serial `push_in`/`data_in_in` interface and assembles two 32-bit operands: dividend z (bytes 0-3, MSB first) and divisor d (bytes 4-7, MSB first).
- Presents the operand pair, together with the mode bits (`sign`, `select`), to the core through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 8.
- NBYTES, 2*WIDTH/8 (localparam), number of bytes per operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push_in  in  1  byte strobe; level signal, one byte per rising edge of the level.
- data_in_in  in  8  byte data, valid while push_in is high.
- sign  in  1  1 = signed division, 0 = unsigned.
- select  in  1  0 = integer radix-2 divide, 1 = fp32 path.
- z_out  out  WIDTH  assembled dividend.
- d_out  out  WIDTH  assembled divisor.
- sign_o  out  1  latched sign for this operation.
- select_o  out  1  latched select for this operation.
- out_valid  out  1  operand pair ready for the core.
- out_ready  in  1  core accepts the operand pair.
- busy  out  1  high while 1..NBYTES-1 bytes have been collected.
- push_drop  out  1  one-cycle pulse when a push is ignored.
- div_zero  out  1  divisor == 0 flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - z_out, d_out, sign_o, select_o, out_valid, busy, push_drop, div_zero = 0.
  - byte counter = 0, push_q = 0, state = COLLECT.
- Edge detect:
  - push_q <= push_in every cycle.
  - A push is "accepted" on a clock edge where push_in=1 and push_q=0.
  - A level held high for N cycles counts as one push.
  - If push_in is already high when reset is released, nothing is accepted until push_in falls and rises again.
- State COLLECT:
  - On accept, the byte shifts in: with cnt<4 into z ({z[WIDTH-9:0],byte}); otherwise into d the same way. cnt increments.
  - On the accept with cnt==0, sign and select are latched into sign_o/select_o. Later changes to sign/select are ignored until the next operation.
  - busy = (cnt != 0) while in COLLECT.
  - On the accept with cnt==NBYTES-1: cnt wraps to 0, state becomes FULL, and out_valid=1 from the same clock edge that stores the last byte (zero added latency).
- State FULL:
  - out_valid stays high; z_out, d_out, sign_o, select_o are held stable.
  - Transfer happens on an edge with out_valid & out_ready. After it, out_valid=0 and state returns to COLLECT.
  - An accepted push while in FULL with out_ready=0 is discarded and push_drop pulses for 1 cycle; cnt is unchanged.
  - Accept on the same edge as a transfer: the byte is taken as byte 0 of the next operation (z shifts it in, sign/select relatched); push_drop stays 0.
  - z_out/d_out may change after a transfer; the core must capture them on the transfer edge.
- out_ready while in COLLECT has no effect.
- Reset in mid-operation aborts the collection; partial bytes are lost and the next accept counts as byte 0.
- No arithmetic is performed. Operand bytes pass through unmodified; signedness is interpreted downstream.

Optional Feature:
- Macro: SRT2_DIVZERO_FLAG_EN.
- Defined:
  - div_zero is registered together with out_valid: 1 iff d == 0 when the last byte is stored; cleared on transfer.
  - This lets the core bypass iteration and return quotient all-ones (unsigned) and remainder = z.
- Undefined: div_zero is tied to 0 and no comparator is built.

Test Plan:
- Unsigned load: after reset, push bytes 0x12,0x34,0x56,0x78,0x00,0x00,0x01,0x23 with sign=0, out_ready=0 -> out_valid=1 on the 8th accept edge; z_out=0x12345678, d_out=0x00000123, sign_o=0; busy=1 after bytes 1-7, 0 after byte 8.
- Held strobe: push_in high for 3 consecutive cycles with data 0xAA -> exactly one byte accepted, cnt=1.
- Backpressure: operand pair pending, out_ready=0, push 0x55 -> push_drop pulses 1 cycle, z_out/d_out unchanged. Then raise out_ready for 1 cycle -> out_valid=0, and the next push is taken as byte 0.
- Simultaneous transfer and push: out_ready=1 on the same edge as a push of 0x9C with sign=1 -> transfer completes, cnt=1, z_out[7:0]=0x9C, sign_o=1, push_drop=0.
- Reset mid-operation: after 5 bytes, pulse rst_n low asynchronously between edges -> all outputs 0 immediately. A following 8-byte sequence 0xFFFFFFF1 / 0x00000003 loads correctly.
- Divide by zero with SRT2_DIVZERO_FLAG_EN defined: z=0x00000064, d=0 -> div_zero=1 with out_valid, cleared on transfer. Without the macro -> div_zero stays 0.

Source files
------------

// File: rtl/srt2_in_packer.sv
// rtl/srt2_in_packer.sv - byte-serial operand packer feeding the SRT radix-2 divider core
// Optional: define SRT2_DIVZERO_FLAG_EN to register a divisor-equals-zero flag with out_valid.
module srt2_in_packer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_in,
  input  logic [7:0]       data_in_in,
  input  logic             sign,
  input  logic             select,
  output logic [WIDTH-1:0] z_out,
  output logic [WIDTH-1:0] d_out,
  output logic             sign_o,
  output logic             select_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             push_drop,
  output logic             div_zero
);

  localparam int NBYTES = 2 * WIDTH / 8;
  localparam int CW     = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [CW-1:0] HALF      = CW'(NBYTES / 2);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            push_q;
  logic            armed;
  logic            accept;
  logic [WIDTH-1:0] z_shift;
  logic [WIDTH-1:0] d_shift;

  // armed stays low after reset until push_in is seen low, so a strobe held
  // high across reset release is not mistaken for a fresh rising edge
  assign accept  = push_in & ~push_q & armed;
  assign z_shift = {z_out[WIDTH-9:0], data_in_in};
  assign d_shift = {d_out[WIDTH-9:0], data_in_in};

  // Rising-edge detector on the byte strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      push_q <= push_in;
      armed  <= armed | ~push_in;
    end
  end

  // Collect/hold FSM: assembles z then d, holds the pair until the core takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      z_out     <= '0;
      d_out     <= '0;
      sign_o    <= 1'b0;
      select_o  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      push_drop <= 1'b0;
    end else begin
      push_drop <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (cnt < HALF) z_out <= z_shift;
            else            d_out <= d_shift;
            if (cnt == '0) begin
              sign_o   <= sign;
              select_o <= select;
            end
            if (cnt == LAST_BYTE) begin
              cnt       <= '0;
              state     <= FULL;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              cnt  <= cnt + 1'b1;
              busy <= 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            // Transfer; a push on the same edge starts the next operation
            out_valid <= 1'b0;
            state     <= COLLECT;
            if (accept) begin
              z_out    <= z_shift;
              sign_o   <= sign;
              select_o <= select;
              cnt      <= CW'(1);
              busy     <= 1'b1;
            end
          end else if (accept) begin
            push_drop <= 1'b1;
          end
        end
        default: begin
          state <= COLLECT;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SRT2_DIVZERO_FLAG_EN
  // Divisor-zero flag, set alongside out_valid from the final divisor value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_zero <= 1'b0;
    end else if (state == COLLECT && accept && cnt == LAST_BYTE) begin
      div_zero <= (d_shift == '0);
    end else if (state == FULL && out_ready) begin
      div_zero <= 1'b0;
    end
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_srt2_in_packer.sv
// tb/tb_srt2_in_packer.sv - directed table-driven bench for srt2_in_packer
module tb_srt2_in_packer;

  logic        clk;
  logic        rst_n;
  logic        push_in;
  logic [7:0]  data_in_in;
  logic        sign;
  logic        select;
  logic [31:0] z_out;
  logic [31:0] d_out;
  logic        sign_o;
  logic        select_o;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        push_drop;
  logic        div_zero;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [7:0] b;
    logic       sgn;
    logic       sel;
    logic       exp_busy;
    logic       exp_valid;
  } vec_t;

  vec_t tbl [0:23];

  srt2_in_packer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_in    (push_in),
    .data_in_in (data_in_in),
    .sign       (sign),
    .select     (select),
    .z_out      (z_out),
    .d_out      (d_out),
    .sign_o     (sign_o),
    .select_o   (select_o),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .push_drop  (push_drop),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " z_out"},     64'(z_out),     64'h0);
    chk({tag, " d_out"},     64'(d_out),     64'h0);
    chk({tag, " sign_o"},    64'(sign_o),    64'h0);
    chk({tag, " select_o"},  64'(select_o),  64'h0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'h0);
    chk({tag, " busy"},      64'(busy),      64'h0);
    chk({tag, " push_drop"}, 64'(push_drop), 64'h0);
    chk({tag, " div_zero"},  64'(div_zero),  64'h0);
  endtask

  // One idle edge with strobe low, then a one-cycle strobe; returns just after the accept edge
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    push_in    = 1'b1;
    data_in_in = b;
    @(negedge clk);
    push_in    = 1'b0;
  endtask

  task automatic run_op(input int base, input string tag);
    for (int i = 0; i < 8; i++) begin
      sign   = tbl[base+i].sgn;
      select = tbl[base+i].sel;
      push_byte(tbl[base+i].b);
      chk($sformatf("%s byte%0d busy", tag, i),      64'(busy),      64'(tbl[base+i].exp_busy));
      chk($sformatf("%s byte%0d out_valid", tag, i), 64'(out_valid), 64'(tbl[base+i].exp_valid));
    end
  endtask

  task automatic transfer;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic exp_dz;
    n_checks = 0;
    n_fail   = 0;

    // op A: unsigned load 0x12345678 / 0x00000123
    tbl[0]  = '{8'h12, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{8'h34, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{8'h56, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{8'h78, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8'h23, 1'b0, 1'b0, 1'b0, 1'b1};
    // op B: signed load 0xFFFFFFF1 / 0x00000003, select toggles after byte 0
    tbl[8]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{8'hF1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b1};
    // op C: divide by zero, z=0x00000064 d=0, fp path selected
    tbl[16] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{8'h64, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[21] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[23] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

`ifdef SRT2_DIVZERO_FLAG_EN
    exp_dz = 1'b1;
`else
    exp_dz = 1'b0;
`endif

    // Reset with strobe held high across release
    rst_n      = 1'b0;
    push_in    = 1'b1;
    data_in_in = 8'hEE;
    sign       = 1'b1;
    select     = 1'b1;
    out_ready  = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("held-through-reset busy", 64'(busy), 64'h0);
    chk("held-through-reset z_out", 64'(z_out), 64'h0);

    // Unsigned load
    run_op(0, "opA");
    chk("opA z_out",    64'(z_out),    64'h12345678);
    chk("opA d_out",    64'(d_out),    64'h00000123);
    chk("opA sign_o",   64'(sign_o),   64'h0);
    chk("opA select_o", 64'(select_o), 64'h0);
    chk("opA div_zero", 64'(div_zero), 64'h0);

    // Backpressure: push while full is dropped
    push_byte(8'h55);
    chk("drop push_drop",  64'(push_drop), 64'h1);
    chk("drop z_out",      64'(z_out),     64'h12345678);
    chk("drop d_out",      64'(d_out),     64'h00000123);
    chk("drop out_valid",  64'(out_valid), 64'h1);
    @(negedge clk);
    chk("drop pulse width", 64'(push_drop), 64'h0);
    transfer();
    chk("xfer out_valid", 64'(out_valid), 64'h0);
    chk("xfer busy",      64'(busy),      64'h0);

    // Held strobe: three cycles high is one byte, and it is byte 0
    sign       = 1'b0;
    select     = 1'b1;
    @(negedge clk);
    push_in    = 1'b1;
    data_in_in = 8'hAA;
    repeat (3) @(negedge clk);
    push_in = 1'b0;
    chk("held busy",     64'(busy),       64'h1);
    chk("held z_lsb",    64'(z_out[7:0]), 64'hAA);
    chk("held sign_o",   64'(sign_o),     64'h0);
    chk("held select_o", 64'(select_o),   64'h1);
    sign   = 1'b1;
    select = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      push_byte(8'(i));
      chk($sformatf("held seq byte%0d out_valid", i), 64'(out_valid), 64'(i == 7));
      chk($sformatf("held seq byte%0d busy", i),      64'(busy),      64'(i != 7));
    end
    chk("held seq z_out",    64'(z_out),    64'hAA010203);
    chk("held seq d_out",    64'(d_out),    64'h04050607);
    chk("held seq sign_o",   64'(sign_o),   64'h0);
    chk("held seq select_o", 64'(select_o), 64'h1);

    // Transfer and accept on the same edge
    @(negedge clk);
    push_in    = 1'b1;
    data_in_in = 8'h9C;
    sign       = 1'b1;
    select     = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    push_in   = 1'b0;
    out_ready = 1'b0;
    chk("simul out_valid", 64'(out_valid), 64'h0);
    chk("simul push_drop", 64'(push_drop), 64'h0);
    chk("simul busy",      64'(busy),      64'h1);
    chk("simul z_out",     64'(z_out),     64'h0102039C);
    chk("simul sign_o",    64'(sign_o),    64'h1);

    // Reach 5 bytes, then an asynchronous reset pulse between edges
    for (int i = 0; i < 4; i++) push_byte(8'h11);
    chk("pre-reset busy", 64'(busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    #1;
    rst_n = 1'b1;

    run_op(8, "opB");
    chk("opB z_out",    64'(z_out),    64'hFFFFFFF1);
    chk("opB d_out",    64'(d_out),    64'h00000003);
    chk("opB sign_o",   64'(sign_o),   64'h1);
    chk("opB select_o", 64'(select_o), 64'h0);
    transfer();
    chk("opB xfer out_valid", 64'(out_valid), 64'h0);

    // Divide by zero operand pair
    run_op(16, "opC");
    chk("opC z_out",    64'(z_out),    64'h00000064);
    chk("opC d_out",    64'(d_out),    64'h0);
    chk("opC select_o", 64'(select_o), 64'h1);
    chk("opC div_zero", 64'(div_zero), 64'(exp_dz));
    transfer();
    chk("opC xfer out_valid", 64'(out_valid), 64'h0);
    chk("opC xfer div_zero",  64'(div_zero),  64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
